// File: rtl/arinc429_rx_word.sv
// ARINC429 bipolar RZ receiver: 32-bit word decode, odd-parity check, display digit unpack.
// Optional LABEL_FILTER_EN: drop parity-good words whose label differs from LABEL_MATCH.
module arinc429_rx_word #(
    parameter int          CLK_HZ      = 50000000,
    parameter int          HS_BPS      = 100000,
    parameter int          LS_BPS      = 12500,
    parameter logic [7:0]  LABEL_MATCH = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_a,
    input  logic        rx_b,
    input  logic        rec_rate,
    output logic [31:0] word,
    output logic [7:0]  label,
    output logic [3:0]  dat0,
    output logic [3:0]  dat1,
    output logic [3:0]  dat2,
    output logic [3:0]  dat3,
    output logic [3:0]  dat4,
    output logic [3:0]  dat5,
    output logic        word_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        busy
);
    localparam int BIT_HS = CLK_HZ / HS_BPS;
    localparam int BIT_LS = CLK_HZ / LS_BPS;
    localparam int TW     = $clog2(2 * CLK_HZ / LS_BPS) + 1;

    typedef enum logic [1:0] {IDLE, BIT_SAMPLE, BIT_WAIT, CHECK} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmr;
    logic [5:0]    cnt;
    logic [31:0]   shreg;
    logic          rx_a_p0, rx_a_p1, rx_a_p2;
    logic          rx_b_p0, rx_b_p1, rx_b_p2;
    logic          rate_q;
    logic          rise_a, rise_b, one_rise, any_rise, rate_chg;
    logic [TW-1:0] qtr_m1, to_m1;
    logic          tmr_clr, shift, ld_n, perr_n, ferr_n;

    function automatic logic odd_parity_ok(input logic [31:0] w);
        return ^w;
    endfunction

    // First received bit (word[0]) becomes the label MSB.
    function automatic logic [7:0] label_of(input logic [31:0] w);
        logic [7:0] l;
        for (int i = 0; i < 8; i++) l[7-i] = w[i];
        return l;
    endfunction

    // Stage p0/p1: synchronizer; stage p2: previous value for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_a_p0 <= 1'b0; rx_a_p1 <= 1'b0; rx_a_p2 <= 1'b0;
            rx_b_p0 <= 1'b0; rx_b_p1 <= 1'b0; rx_b_p2 <= 1'b0;
            rate_q  <= 1'b0;
        end else begin
            rx_a_p0 <= rx_a;    rx_a_p1 <= rx_a_p0; rx_a_p2 <= rx_a_p1;
            rx_b_p0 <= rx_b;    rx_b_p1 <= rx_b_p0; rx_b_p2 <= rx_b_p1;
            rate_q  <= rec_rate;
        end
    end

    assign rise_a   = rx_a_p1 & ~rx_a_p2;
    assign rise_b   = rx_b_p1 & ~rx_b_p2;
    assign one_rise = (rise_a ^ rise_b) & (rx_a_p1 ^ rx_b_p1);
    assign any_rise = rise_a | rise_b;
    assign rate_chg = rec_rate ^ rate_q;
    assign qtr_m1   = rate_q ? TW'(BIT_HS / 4 - 1) : TW'(BIT_LS / 4 - 1);
    assign to_m1    = rate_q ? TW'(2 * BIT_HS - 1) : TW'(2 * BIT_LS - 1);

    always_comb begin
        state_n = state;
        tmr_clr = 1'b0;
        shift   = 1'b0;
        ld_n    = 1'b0;
        perr_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (one_rise) begin
                    state_n = BIT_SAMPLE;
                    tmr_clr = 1'b1;
                end
            end
            BIT_SAMPLE: begin
                if (tmr == qtr_m1) begin
                    if (rx_a_p1 ^ rx_b_p1) begin
                        shift   = 1'b1;
                        state_n = (cnt == 6'd31) ? CHECK : BIT_WAIT;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            BIT_WAIT: begin
                // Any edge goes to sampling so a both-rails-high bit is caught there.
                if (any_rise) begin
                    state_n = BIT_SAMPLE;
                    tmr_clr = 1'b1;
                end else if (tmr >= to_m1) begin
                    ferr_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            CHECK: begin
                state_n = IDLE;
                if (odd_parity_ok(shreg)) begin
`ifdef LABEL_FILTER_EN
                    ld_n = (label_of(shreg) == LABEL_MATCH);
`else
                    ld_n = 1'b1;
`endif
                end else begin
                    perr_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        // A speed change mid-word abandons the word quietly.
        if (rate_chg && state != IDLE) begin
            state_n = IDLE;
            tmr_clr = 1'b0;
            shift   = 1'b0;
            ld_n    = 1'b0;
            perr_n  = 1'b0;
            ferr_n  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmr        <= '0;
            cnt        <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            word_valid <= ld_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
            if (tmr_clr)             tmr <= '0;
            else if (state != IDLE)  tmr <= tmr + 1'b1;
            if (state == IDLE)       cnt <= '0;
            else if (shift)          cnt <= cnt + 1'b1;
            if (ld_n)                word <= shreg;
        end
    end

    // Bits arrive LSB-first into word, so shift in from the top.
    always_ff @(posedge clk) begin
        if (shift) shreg <= {rx_a_p1, shreg[31:1]};
    end

    assign busy  = (state != IDLE);
    assign label = label_of(word);
    assign dat0  = word[11:8];
    assign dat1  = word[15:12];
    assign dat2  = word[19:16];
    assign dat3  = word[23:20];
    assign dat4  = word[27:24];
    assign dat5  = {1'b0, word[30:28]};

endmodule

// File: tb/tb_arinc429_rx_word.sv
// Bench for arinc429_rx_word: directed plan items plus randomized words against a word-level model.
module tb_arinc429_rx_word;
    localparam int CLK_HZ = 4000000;
    localparam int HS     = 100000;
    localparam int LS     = 12500;
    localparam int BIT_HS = CLK_HZ / HS;
    localparam int BIT_LS = CLK_HZ / LS;
`ifdef LABEL_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk, rst, rx_a, rx_b, rec_rate;
    logic [31:0] word;
    logic [7:0]  label;
    logic [3:0]  dat0, dat1, dat2, dat3, dat4, dat5;
    logic        word_valid, parity_err, frame_err, busy;

    arinc429_rx_word #(.CLK_HZ(CLK_HZ), .HS_BPS(HS), .LS_BPS(LS), .LABEL_MATCH(8'h3C)) dut (
        .clk(clk), .rst(rst), .rx_a(rx_a), .rx_b(rx_b), .rec_rate(rec_rate),
        .word(word), .label(label),
        .dat0(dat0), .dat1(dat1), .dat2(dat2), .dat3(dat3), .dat4(dat4), .dat5(dat5),
        .word_valid(word_valid), .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vld = 0, n_perr = 0, n_ferr = 0;
    always @(negedge clk) begin
        if (word_valid) n_vld++;
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
    end

    int n_chk = 0, n_err = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [31:0] m_word = '0;

    function automatic logic [7:0] m_label(input logic [31:0] w);
        logic [7:0] l;
        for (int i = 0; i < 8; i++) l[7-i] = w[i];
        return l;
    endfunction

    function automatic logic [31:0] make_word(input logic [7:0] lbl, input logic [3:0] d0, d1, d2, d3, d4,
                                              input logic [2:0] d5, input bit good);
        logic [31:0] w;
        for (int i = 0; i < 8; i++) w[i] = lbl[7-i];
        w[30:8] = {d5, d4, d3, d2, d1, d0};
        w[31]   = ~(^w[30:0]) ^ !good;
        return w;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".word"},  word, m_word);
        check({tag, ".label"}, {24'd0, label}, {24'd0, m_label(m_word)});
        check({tag, ".dat0"},  {28'd0, dat0}, (m_word >> 8)  & 32'hF);
        check({tag, ".dat1"},  {28'd0, dat1}, (m_word >> 12) & 32'hF);
        check({tag, ".dat2"},  {28'd0, dat2}, (m_word >> 16) & 32'hF);
        check({tag, ".dat3"},  {28'd0, dat3}, (m_word >> 20) & 32'hF);
        check({tag, ".dat4"},  {28'd0, dat4}, (m_word >> 24) & 32'hF);
        check({tag, ".dat5"},  {28'd0, dat5}, (m_word >> 28) & 32'h7);
    endtask

    task automatic drive_bit(input logic a, input logic b, input int bitclks);
        rx_a = a; rx_b = b;
        repeat (bitclks / 2) @(posedge clk);
        #1; rx_a = 1'b0; rx_b = 1'b0;
        repeat (bitclks / 2) @(posedge clk);
        #1;
    endtask

    // Sends nbits of w (bit k carries w[k-1]); bit bad_bit (1-based) drives both rails high.
    task automatic run_word(input string tag, input logic [31:0] w, input int nbits,
                            input int bad_bit, input int bitclks);
        int v0, p0, f0, ev, ep, ef;
        v0 = n_vld; p0 = n_perr; f0 = n_ferr;
        ev = 0; ep = 0; ef = 0;
        for (int k = 1; k <= nbits; k++) begin
            if (k == bad_bit) drive_bit(1'b1, 1'b1, bitclks);
            else              drive_bit(w[k-1], ~w[k-1], bitclks);
        end
        if (nbits < 32 || bad_bit >= 1)        ef = 1;
        else if (^w == 1'b0)                   ep = 1;
        else if (FILT && m_label(w) != 8'h3C)  ev = 0;
        else begin ev = 1; m_word = w; end
        repeat (3 * bitclks) @(posedge clk);
        #1;
        check({tag, ".vld"},  n_vld - v0,  ev);
        check({tag, ".perr"}, n_perr - p0, ep);
        check({tag, ".ferr"}, n_ferr - f0, ef);
        check({tag, ".busy"}, {31'd0, busy}, 32'd0);
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] w;
        int v0, p0, f0;
        rst = 1'b1; rx_a = 1'b0; rx_b = 1'b0; rec_rate = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst.vld",  {31'd0, word_valid}, 32'd0);
        check("rst.perr", {31'd0, parity_err}, 32'd0);
        check("rst.ferr", {31'd0, frame_err},  32'd0);
        check("rst.busy", {31'd0, busy},       32'd0);
        check_outputs("rst");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        w = make_word(8'hA5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 3'd6, 1'b1);
        run_word("hs_good", w, 32, 0, BIT_HS);
        check("hs_good.lbl", {24'd0, label}, 32'hA5);
        check("hs_good.d5",  {28'd0, dat5},  32'd6);
        w[31] = ~w[31];
        run_word("hs_par", w, 32, 0, BIT_HS);

        // Speed change mid-word: quiet abort, new speed for the next word
        v0 = n_vld; p0 = n_perr; f0 = n_ferr;
        w = make_word(8'h11, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 3'd4, 1'b1);
        for (int k = 1; k <= 5; k++) drive_bit(w[k-1], ~w[k-1], BIT_HS);
        check("abort.busy_mid", {31'd0, busy}, 32'd1);
        rec_rate = 1'b0;
        repeat (3 * BIT_HS) @(posedge clk);
        #1;
        check("abort.busy", {31'd0, busy}, 32'd0);
        check("abort.evts", (n_vld - v0) + (n_perr - p0) + (n_ferr - f0), 32'd0);
        check_outputs("abort");

        run_word("ls_good", w, 32, 0, BIT_LS);
        run_word("ls_tmo", make_word(8'h22, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 3'd3, 1'b1), 15, 0, BIT_LS);

        rec_rate = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        w = make_word(8'h5A, 4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 3'd7, 1'b1);
        run_word("both_hi", w, 10, 10, BIT_HS);
        run_word("after", w, 32, 0, BIT_HS);

        run_word("lbl3c", make_word(8'h3C, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 3'd0, 1'b1), 32, 0, BIT_HS);
        run_word("lbl3d", make_word(8'h3D, 4'd2, 4'd4, 4'd6, 4'd8, 4'hA, 3'd5, 1'b1), 32, 0, BIT_HS);

        for (int i = 0; i < 10; i++) begin
            logic [7:0] lbl;
            lbl = ($urandom_range(0, 1) == 0) ? 8'h3C : 8'($urandom);
            w = make_word(lbl, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                          4'($urandom), 3'($urandom), $urandom_range(0, 3) != 0);
            run_word($sformatf("rnd%0d", i), w, 32, 0, BIT_HS);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
